// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among N_REQ requesters.
// Packets are never interleaved; an optional ID header byte precedes each packet.
module uart_tx_arbiter #(
  parameter int          N_REQ     = 4,
  parameter bit          ID_HEADER = 1'b1,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] ReqData,
  input  logic [N_REQ-1:0]   ReqLast,
  output logic [N_REQ-1:0]   ReqAck,
  output logic [N_REQ-1:0]   Grant,
  output logic               Abort,
  output logic               Busy,
  output logic               TxEn,
  output logic [7:0]         TxData,
  input  logic               TxDone
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, HDR, HDR_WAIT, LOAD, SEND_WAIT} state_t;

  state_t            state, stateNext;
  logic [IW-1:0]     gId, gIdNext, rrPtr, rrPtrNext, nextPtr;
  logic              lastQ, lastNext;
  logic [15:0]       cnt, cntNext;
  logic [N_REQ-1:0]  grantNext, ackNext;
  logic              txEnNext, abortNext;
  logic [7:0]        txDataNext;
  logic [7:0]        reqByte [N_REQ];
  logic [IW-1:0]     cand, pick;
  logic              found;

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign reqByte[i] = ReqData[8*i +: 8];
  end

  assign nextPtr = (int'(gId) == N_REQ - 1) ? '0 : gId + 1'b1;

  // First requester at or after rrPtr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(rrPtr) + i) % N_REQ);
      if (!found && Req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    gIdNext    = gId;
    rrPtrNext  = rrPtr;
    lastNext   = lastQ;
    cntNext    = cnt;
    grantNext  = Grant;
    ackNext    = '0;
    txEnNext   = 1'b0;
    abortNext  = 1'b0;
    txDataNext = TxData;
    case (state)
      IDLE: begin
        if (found) begin
          gIdNext         = pick;
          grantNext       = '0;
          grantNext[pick] = 1'b1;
          cntNext         = '0;
          stateNext       = ID_HEADER ? HDR : LOAD;
        end
      end
      HDR: begin
        txDataNext = 8'hA0 | 8'(gId);
        txEnNext   = 1'b1;
        stateNext  = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (TxDone) begin
          cntNext   = '0;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (Req[gId]) begin
          txDataNext   = reqByte[gId];
          txEnNext     = 1'b1;
          ackNext[gId] = 1'b1;
          lastNext     = ReqLast[gId];
          cntNext      = '0;
          stateNext    = SEND_WAIT;
        end else if (cnt >= TIMEOUT - 16'd1) begin
          // Stalled owner: release the link and move past it.
          abortNext = 1'b1;
          grantNext = '0;
          rrPtrNext = nextPtr;
          cntNext   = '0;
          stateNext = IDLE;
        end else begin
          cntNext = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
      end
      SEND_WAIT: begin
        if (TxDone) begin
          if (lastQ) begin
            grantNext = '0;
            rrPtrNext = nextPtr;
            stateNext = IDLE;
          end else begin
            cntNext   = '0;
            stateNext = LOAD;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      gId    <= '0;
      rrPtr  <= '0;
      lastQ  <= 1'b0;
      cnt    <= '0;
      Grant  <= '0;
      ReqAck <= '0;
      Abort  <= 1'b0;
      Busy   <= 1'b0;
      TxEn   <= 1'b0;
      TxData <= 8'h00;
    end else begin
      state  <= stateNext;
      gId    <= gIdNext;
      rrPtr  <= rrPtrNext;
      lastQ  <= lastNext;
      cnt    <= cntNext;
      Grant  <= grantNext;
      ReqAck <= ackNext;
      Abort  <= abortNext;
      Busy   <= (stateNext != IDLE);
      TxEn   <= txEnNext;
      TxData <= txDataNext;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reactive requesters and UART model,
// expected TX byte stream kept in a scoreboard queue.
module tb_uart_tx_arbiter;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [3:0]  Req, ReqLast, ReqAck, Grant;
  logic [31:0] ReqData;
  logic        Abort, Busy, TxEn, TxDone;
  logic [7:0]  TxData;

  logic [3:0]  ReqB, ReqLastB, ReqAckB, GrantB;
  logic [31:0] ReqDataB;
  logic        AbortB, BusyB, TxEnB, TxDoneB;
  logic [7:0]  TxDataB;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.N_REQ(4), .ID_HEADER(1'b1), .TIMEOUT(16'd20)) dutA (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqData(ReqData), .ReqLast(ReqLast),
    .ReqAck(ReqAck), .Grant(Grant), .Abort(Abort), .Busy(Busy),
    .TxEn(TxEn), .TxData(TxData), .TxDone(TxDone));

  uart_tx_arbiter #(.N_REQ(4), .ID_HEADER(1'b0), .TIMEOUT(16'd20)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .Req(ReqB), .ReqData(ReqDataB), .ReqLast(ReqLastB),
    .ReqAck(ReqAckB), .Grant(GrantB), .Abort(AbortB), .Busy(BusyB),
    .TxEn(TxEnB), .TxData(TxDataB), .TxDone(TxDoneB));

  always #5 Clk = ~Clk;

  logic [7:0] expQ [$];
  logic [7:0] pendData [4][8];
  bit         pendLast [4][8];
  int         pendLen [4];
  int         pendIdx [4];
  int         ackCount [4];
  int         txEnCount = 0, txEnCountB = 0, abortCount = 0;
  int         cyc = 0, doneCyc = 0, abortDelta = 0;
  logic [3:0] grantSeen = '0;
  bit         txBusy = 1'b0;
  int         txCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on every TX start plus per-cycle invariants.
  always @(negedge Clk) begin
    cyc++;
    if (TxEnB) txEnCountB++;
    if (Rst_n) begin
      chk("busy_vs_grant", {31'd0, Busy}, {31'd0, |Grant});
      chk("ack_granted", {28'd0, ReqAck & ~Grant}, 32'd0);
      grantSeen |= Grant;
      for (int i = 0; i < 4; i++) if (ReqAck[i]) ackCount[i]++;
      if (TxDone) doneCyc = cyc;
      if (Abort) begin
        abortCount++;
        abortDelta = cyc - doneCyc;
        chk("abort_grant", {28'd0, Grant}, 32'd0);
      end
      if (TxEn) begin
        txEnCount++;
        chk("sb_nonempty", expQ.size(), 32'd1 * (expQ.size() != 0 ? expQ.size() : 1));
        if (expQ.size() != 0) chk("txdata", {24'd0, TxData}, {24'd0, expQ.pop_front()});
      end
    end
  end

  task automatic clearPend();
    for (int i = 0; i < 4; i++) begin
      pendLen[i] = 0;
      pendIdx[i] = 0;
    end
  endtask

  task automatic addByte(input int i, input logic [7:0] d, input bit last);
    pendData[i][pendLen[i]] = d;
    pendLast[i][pendLen[i]] = last;
    pendLen[i]++;
  endtask

  task automatic loadReq(input int i);
    if (pendIdx[i] < pendLen[i]) begin
      Req[i]           = 1'b1;
      ReqData[8*i +: 8] = pendData[i][pendIdx[i]];
      ReqLast[i]       = pendLast[i][pendIdx[i]];
    end else begin
      Req[i]     = 1'b0;
      ReqLast[i] = 1'b0;
    end
  endtask

  task automatic startAll();
    for (int i = 0; i < 4; i++) loadReq(i);
  endtask

  // One clock: UART model answers each TxEn with TxDone a few cycles later,
  // requesters present their next byte after each ReqAck.
  task automatic step();
    @(posedge Clk);
    #1;
    TxDone = 1'b0;
    if (txBusy) begin
      if (txCnt == 0) begin
        TxDone = 1'b1;
        txBusy = 1'b0;
      end else txCnt--;
    end
    if (TxEn) begin
      txBusy = 1'b1;
      txCnt  = 2;
    end
    for (int i = 0; i < 4; i++) if (ReqAck[i]) begin
      pendIdx[i]++;
      loadReq(i);
    end
  endtask

  function automatic bit allSent();
    for (int i = 0; i < 4; i++) if (pendIdx[i] < pendLen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int maxCyc);
    bit done = 1'b0;
    for (int n = 0; n < maxCyc && !done; n++) begin
      step();
      done = allSent() && !Busy && !txBusy && !TxDone;
    end
    chk(tag, {31'd0, done}, 32'd1);
    chk({tag, "_sb_empty"}, expQ.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, ack0, ab0;
    bit seen;
    Rst_n = 1'b0; Req = '0; ReqData = '0; ReqLast = '0; TxDone = 1'b0;
    ReqB = '0; ReqDataB = '0; ReqLastB = '0; TxDoneB = 1'b0;
    for (int i = 0; i < 4; i++) ackCount[i] = 0;
    clearPend();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_grant", {28'd0, Grant}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_txen", {31'd0, TxEn}, 32'd0);
    chk("rst_txdata", {24'd0, TxData}, 32'd0);
    chk("rst_ack_abort", {27'd0, ReqAck, Abort}, 32'd0);
    chk("rstB_grant_busy", {27'd0, GrantB, BusyB}, 32'd0);
    Rst_n = 1'b1;
    step();

    // No header: data TxEn and ReqAck in the same cycle, single TxEn.
    ReqB = 4'b0001; ReqDataB[7:0] = 8'h5A; ReqLastB = 4'b0001;
    step();
    chk("nohdr_grant", {27'd0, GrantB, BusyB}, {27'd0, 4'b0001, 1'b1});
    step();
    chk("nohdr_txen", {31'd0, TxEnB}, 32'd1);
    chk("nohdr_txdata", {24'd0, TxDataB}, 32'h5A);
    chk("nohdr_ack", {28'd0, ReqAckB}, 32'd1);
    ReqB = '0; ReqLastB = '0;
    step(); step();
    TxDoneB = 1'b1;
    step();
    TxDoneB = 1'b0;
    chk("nohdr_release", {27'd0, GrantB, BusyB}, 32'd0);
    step();
    chk("nohdr_txen_count", txEnCountB, 32'd1);

    // Contention from rrPtr=0: one-byte packets, requester 0 queues two.
    clearPend();
    addByte(0, 8'hC0, 1); addByte(0, 8'hC1, 1);
    addByte(1, 8'hD1, 1); addByte(2, 8'hD2, 1); addByte(3, 8'hD3, 1);
    expQ = '{8'hA0, 8'hC0, 8'hA1, 8'hD1, 8'hA2, 8'hD2, 8'hA3, 8'hD3, 8'hA0, 8'hC1};
    startAll();
    drain("contention", 400);

    // Single requester 2 with header latency check; leaves rrPtr at 3.
    clearPend();
    addByte(2, 8'h11, 0); addByte(2, 8'h22, 1);
    expQ.push_back(8'hA2); expQ.push_back(8'h11); expQ.push_back(8'h22);
    en0 = txEnCount; ack0 = ackCount[2]; grantSeen = '0;
    startAll();
    step();
    chk("single_grant", {27'd0, Grant, Busy}, {27'd0, 4'b0100, 1'b1});
    step();
    chk("single_hdr_txen", {23'd0, TxEn, TxData}, {23'd0, 1'b1, 8'hA2});
    drain("single", 100);
    chk("single_txen_count", txEnCount - en0, 32'd3);
    chk("single_ack_count", ackCount[2] - ack0, 32'd2);
    chk("single_grant_seen", {28'd0, grantSeen}, 32'h4);
    chk("single_grant_clear", {28'd0, Grant}, 32'd0);

    // Wrap: rrPtr=3 with requesters 0 and 3 -> 3 first, then 0.
    clearPend();
    addByte(3, 8'h33, 1); addByte(0, 8'h44, 1);
    expQ = '{8'hA3, 8'h33, 8'hA0, 8'h44};
    startAll();
    drain("wrap", 200);

    // Timeout: requester 1 stalls mid-packet; requester 2 gets the link next.
    clearPend();
    addByte(1, 8'h55, 0); addByte(2, 8'h66, 1);
    expQ = '{8'hA1, 8'h55, 8'hA2, 8'h66};
    ab0 = abortCount;
    startAll();
    drain("timeout", 300);
    chk("timeout_abort_count", abortCount - ab0, 32'd1);
    chk("timeout_abort_delay", abortDelta, 32'd21);

    // Reset while waiting for a data byte's TxDone.
    clearPend();
    addByte(1, 8'h77, 0); addByte(1, 8'h78, 1);
    expQ = '{8'hA1, 8'h77};
    startAll();
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      step();
      if (ReqAck[1]) seen = 1'b1;
    end
    chk("rstmid_ack_seen", {31'd0, seen}, 32'd1);
    @(negedge Clk);
    #1;
    Rst_n = 1'b0; Req = '0; ReqLast = '0; txBusy = 1'b0; TxDone = 1'b0;
    #1;
    chk("rstmid_grant_busy", {27'd0, Grant, Busy}, 32'd0);
    chk("rstmid_tx", {23'd0, TxEn, TxData}, 32'd0);
    chk("rstmid_ack_abort", {27'd0, ReqAck, Abort}, 32'd0);
    clearPend();
    expQ.delete();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    addByte(1, 8'h88, 1); addByte(3, 8'h99, 1);
    expQ = '{8'hA1, 8'h88, 8'hA3, 8'h99};
    startAll();
    step();
    chk("rstmid_restart_grant", {28'd0, Grant}, 32'h2);
    drain("rstmid_restart", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares the single UART transmitter among N_REQ on-chip requesters (processor cores). It sits between the cores and the UART top-level TX inputs (TxEn, TxData), consumes TxDone, and sends each packet without interleaving. Each packet is optionally prefixed with a header byte carrying the requester ID. An idle-timeout stops a stalled requester from holding the link.

## Interface
- N_REQ, default 4: number of requesters, 2..16.
- ID_HEADER, default 1: 1 sends header byte 8'hA0 | {4'b0, id} before each packet; 0 sends no header.
- TIMEOUT, default 16'd50000: clock cycles a granted requester may leave Req low mid-packet before the grant is revoked. 0 is not allowed.

Ports:
- Clk  in  1  single system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Req  in  N_REQ  per-requester byte-valid, level.
- ReqData  in  8*N_REQ  byte for requester i at bits [8i+7:8i]. Stable while Req[i]=1 until ReqAck[i].
- ReqLast  in  N_REQ  marks the current byte as the last of its packet. Qualified with Req.
- ReqAck  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- Grant  out  N_REQ  one-hot current owner, or all-zero.
- Abort  out  1  one-cycle pulse when a grant is revoked by timeout.
- Busy  out  1  high whenever the state is not IDLE.
- TxEn  out  1  one-cycle start pulse to the UART transmitter.
- TxData  out  8  byte to transmit. Held from the TxEn pulse until the matching TxDone.
- TxDone  in  1  one-cycle pulse from the UART transmitter at end of stop bit.

## Operation
States: IDLE, HDR, HDR_WAIT, LOAD, SEND_WAIT. All outputs are registered.

- IDLE: if Req != 0, pick the first set bit scanning from rr_ptr upward with wrap.
  - Latch its id g and set Grant = onehot(g).
  - Go to HDR if ID_HEADER=1, else go to LOAD.
- HDR: TxData <= 8'hA0 | g and TxEn pulses. Go to HDR_WAIT.
- HDR_WAIT: on TxDone, go to LOAD.
- LOAD:
  - If Req[g]=1: TxData <= ReqData[g], TxEn pulses, ReqAck[g] pulses, last_q <= ReqLast[g], timeout counter clears. Go to SEND_WAIT.
  - If Req[g]=0: the timeout counter increments. When it reaches TIMEOUT-1: Abort pulses, Grant <= 0, rr_ptr <= (g+1) mod N_REQ. Go to IDLE.
- SEND_WAIT: on TxDone:
  - If last_q=1: Grant <= 0, rr_ptr <= (g+1) mod N_REQ. Go to IDLE.
  - Otherwise go to LOAD.
- Requests from non-granted requesters are ignored. Their ReqAck stays 0, with no pre-emption mid-packet.
- TxDone outside HDR_WAIT/SEND_WAIT is ignored.
- A requester may raise Req again on the cycle after its ReqAck.
- Timeout counter: 16 bits, saturating, cleared on every state entry to LOAD from SEND_WAIT/HDR_WAIT.

## Timing
- Reset values: Grant=0, ReqAck=0, Abort=0, Busy=0, TxEn=0, TxData=8'h00, rr_ptr=0, state=IDLE, counter=0. Reset asserted mid-frame forces these values immediately; no partial packet resumes.
- Requests arbitrated and granted:
  - Req seen in IDLE at edge k: Grant and Busy valid after edge k.
  - With ID_HEADER=1, TxEn (header) is high in the cycle after edge k+1.
  - With ID_HEADER=0, TxEn (data) and ReqAck are high in the cycle after edge k+1. Both pulse in the same cycle.
- Bytes within a packet: after TxDone at edge m, the next data TxEn occurs after edge m+1 if Req[g] is already high.
- After the last TxDone, Grant clears. Earliest next Grant is one cycle later, when IDLE re-arbitrates.
- Simultaneous events: Req and ReqLast are sampled only in LOAD. If Req[g] rises in the cycle the timeout expires, the timeout wins.

## Test plan
- Single requester, ID_HEADER=1, N_REQ=4:
  - Stimulus: Req[2] sends 8'h11 then 8'h22 with Last on the second byte.
  - Required: TxData sequence A2, 11, 22, with exactly 3 TxEn pulses, 2 ReqAck[2] pulses, Grant=4'b0100 throughout, then 0. rr_ptr=3.
- Contention: Req=4'b1111 held, one-byte packets each.
  - Required: header order A0, A1, A2, A3, A0. No byte of one packet between another's header and last byte.
- Wrap: rr_ptr=3 with Req=4'b1001.
  - Required: requester 3 granted first, then 0.
- Timeout, TIMEOUT=20: requester 1 sends one non-last byte, then drops Req.
  - Required: Abort pulses exactly 20 cycles after entering LOAD, Grant→0, next grant goes to requester 2 if requesting.
- ID_HEADER=0: Req[0] sends 8'h5A with Last.
  - Required: only one TxEn, with TxData=5A and ReqAck[0] in the same cycle.
- Reset in SEND_WAIT: all outputs return to reset values.
  - Required: after release with Req[1]=1, arbitration restarts from rr_ptr=0 and requester 1 wins.
